// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60) and small sizing helpers used by the
// timing generator and the display core.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_COLOR_W  = 8;

  typedef struct packed {
    logic [DEF_COLOR_W-1:0] r;
    logic [DEF_COLOR_W-1:0] g;
    logic [DEF_COLOR_W-1:0] b;
  } rgb_t;

  function automatic int timing_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int rgb_width(input int color_w);
    return 3 * color_w;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-clock divider, H/V counters, stage-0 syncs/active, start-of-frame and
// completed-frame counter.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             power,
  output logic             pix_en,
  output logic             pix_step,
  output logic             vga_clk,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             active,
  output logic             hsync,
  output logic             vsync,
  output logic             sof,
  output logic [15:0]      frame_cnt
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if ((2 ** CNT_W) <= H_TOTAL || (2 ** CNT_W) <= V_TOTAL) begin : g_cnt_chk
    $fatal(1, "vga_timing: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  logic [DIV_W-1:0] div_cnt_reg;
  logic [CNT_W-1:0] hcount_reg;
  logic [CNT_W-1:0] vcount_reg;
  logic [15:0]      frame_cnt_reg;
  logic             started_reg;
  logic             h_wrap;
  logic             v_wrap;

  assign pix_en   = (div_cnt_reg == DIV_LAST);
  assign pix_step = pix_en && started_reg;
  assign vga_clk  = (div_cnt_reg >= DIV_HALF);
  assign h_wrap   = (hcount_reg == H_LAST);
  assign v_wrap   = (vcount_reg == V_LAST);
  // The first tick after reset opens frame 0 in place instead of advancing.
  assign sof      = pix_en && (!started_reg || (h_wrap && v_wrap));

  always_ff @(posedge clk) begin
    if (!power) begin
      div_cnt_reg   <= '0;
      hcount_reg    <= '0;
      vcount_reg    <= '0;
      frame_cnt_reg <= '0;
      started_reg   <= 1'b0;
    end else begin
      div_cnt_reg <= pix_en ? '0 : div_cnt_reg + DIV_W'(1);
      if (pix_en) begin
        started_reg <= 1'b1;
      end
      if (pix_step) begin
        if (h_wrap) begin
          hcount_reg <= '0;
          vcount_reg <= v_wrap ? '0 : vcount_reg + CNT_W'(1);
        end else begin
          hcount_reg <= hcount_reg + CNT_W'(1);
        end
        if (h_wrap && v_wrap) begin
          frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
      end
    end
  end

  assign hcount    = hcount_reg;
  assign vcount    = vcount_reg;
  assign frame_cnt = frame_cnt_reg;
  assign active    = (hcount_reg < H_ACT) && (vcount_reg < V_ACT);
  assign hsync     = (hcount_reg >= HS_BEG) && (hcount_reg < HS_END);
  assign vsync     = (vcount_reg >= VS_BEG) && (vcount_reg < VS_END);

endmodule

// File: rtl/vga_display_core.sv
// VGA output path: frame-synchronous source mux, control delay line matched to
// the source pipeline latency, blanking and registered DAC pins.
module vga_display_core
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int NUM_SRC   = 2,
  parameter int COLOR_W   = DEF_COLOR_W,
  parameter int CNT_W     = 10,
  parameter int PIPE_LAT  = 0,
  localparam int SEL_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int RGB_W    = rgb_width(COLOR_W)
) (
  input  logic                     clk,
  input  logic                     power,
  input  logic [SEL_W-1:0]         src_sel,
  input  logic [NUM_SRC*RGB_W-1:0] src_rgb,
  output logic [CNT_W-1:0]         hcount,
  output logic [CNT_W-1:0]         vcount,
  output logic                     active,
  output logic                     pix_en,
  output logic                     sof,
  output logic [15:0]              frame_cnt,
  output logic                     VGA_clk,
  output logic                     VGA_Hsync,
  output logic                     VGA_Vsync,
  output logic                     VGA_Display,
  output logic [COLOR_W-1:0]       VGA_Red,
  output logic [COLOR_W-1:0]       VGA_Green,
  output logic [COLOR_W-1:0]       VGA_Blue
);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_div_chk
    $fatal(1, "vga_display_core: CLK_DIV must be even and >= 2");
  end
  if (PIPE_LAT < 0 || PIPE_LAT > 3) begin : g_lat_chk
    $fatal(1, "vga_display_core: PIPE_LAT must be 0..3");
  end

  logic             hsync_0;
  logic             vsync_0;
  logic             pix_step;
  logic [2:0]       ctl_0;
  logic [2:0]       ctl_d;
  logic [SEL_W-1:0] cur_src_reg;
  logic [RGB_W-1:0] rgb_reg;
  logic [RGB_W-1:0] src_arr [NUM_SRC];

  vga_timing #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CNT_W   (CNT_W)
  ) u_timing (
    .clk      (clk),
    .power    (power),
    .pix_en   (pix_en),
    .pix_step (pix_step),
    .vga_clk  (VGA_clk),
    .hcount   (hcount),
    .vcount   (vcount),
    .active   (active),
    .hsync    (hsync_0),
    .vsync    (vsync_0),
    .sof      (sof),
    .frame_cnt(frame_cnt)
  );

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_arr[gi] = src_rgb[gi*RGB_W +: RGB_W];
  end

  // Out-of-range requests keep the current source.
  always_ff @(posedge clk) begin
    if (!power) begin
      cur_src_reg <= '0;
    end else if (sof && (32'(src_sel) < NUM_SRC)) begin
      cur_src_reg <= src_sel;
    end
  end

  // Controls are carried as asserted-high flags; polarity is applied at the pins.
  assign ctl_0 = {hsync_0, vsync_0, active};

  if (PIPE_LAT == 0) begin : g_nodly
    assign ctl_d = ctl_0;
  end else begin : g_dly
    logic [2:0] sr_reg [PIPE_LAT];
    always_ff @(posedge clk) begin
      if (!power) begin
        for (int i = 0; i < PIPE_LAT; i++) sr_reg[i] <= '0;
      end else if (pix_step) begin
        sr_reg[0] <= ctl_0;
        for (int i = 1; i < PIPE_LAT; i++) sr_reg[i] <= sr_reg[i-1];
      end
    end
    assign ctl_d = sr_reg[PIPE_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (!power) begin
      VGA_Hsync   <= ~HSYNC_POL;
      VGA_Vsync   <= ~VSYNC_POL;
      VGA_Display <= 1'b0;
      rgb_reg     <= '0;
    end else if (pix_step) begin
      VGA_Hsync   <= ctl_d[2] ? HSYNC_POL : ~HSYNC_POL;
      VGA_Vsync   <= ctl_d[1] ? VSYNC_POL : ~VSYNC_POL;
      VGA_Display <= ctl_d[0];
      rgb_reg     <= ctl_d[0] ? src_arr[cur_src_reg] : '0;
    end
  end

  assign {VGA_Red, VGA_Green, VGA_Blue} = rgb_reg;

endmodule

// File: tb/tb_vga_display_core.sv
// Randomised bench for vga_display_core: expected pins are derived arithmetically
// from the number of clk edges since reset release.
module tb_vga_display_core;

  localparam int CLK_DIV = 4;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 5, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam bit HPOL = 1'b1, VPOL = 1'b0;
  localparam int NUM_SRC = 3, COLOR_W = 8, CNT_W = 6, PIPE_LAT = 2;
  localparam int SEL_W = 2;
  localparam int WHITE_F = 3;
  localparam int RST_TICK = 5 * FRAME + 1 + 3 * HT + 4;

  logic clk = 1'b0;
  logic power = 1'b0;
  logic [SEL_W-1:0] src_sel = '0;
  logic [NUM_SRC*3*COLOR_W-1:0] src_rgb = '0;
  logic [CNT_W-1:0] hcount, vcount;
  logic active, pix_en, sof;
  logic [15:0] frame_cnt;
  logic VGA_clk, VGA_Hsync, VGA_Vsync, VGA_Display;
  logic [COLOR_W-1:0] VGA_Red, VGA_Green, VGA_Blue;

  vga_display_core #(
    .CLK_DIV(CLK_DIV),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL),
    .NUM_SRC(NUM_SRC), .COLOR_W(COLOR_W), .CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .power(power), .src_sel(src_sel), .src_rgb(src_rgb),
    .hcount(hcount), .vcount(vcount), .active(active), .pix_en(pix_en),
    .sof(sof), .frame_cnt(frame_cnt), .VGA_clk(VGA_clk),
    .VGA_Hsync(VGA_Hsync), .VGA_Vsync(VGA_Vsync), .VGA_Display(VGA_Display),
    .VGA_Red(VGA_Red), .VGA_Green(VGA_Green), .VGA_Blue(VGA_Blue)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int cur_model = 0;
  int frame_src [64];
  int salt [NUM_SRC];
  bit running = 1'b0;
  bit mid_reset_done = 1'b0;
  int last_sof_k = -1;
  int white_on = 0;
  int white_off = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    if (obs !== expd) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (k=%0d)", tag, obs, expd, k);
    end
  endtask

  // Bit generator content for pixel index n; frame WHITE_F of the first run is all-white.
  function automatic logic [23:0] src_pix(input int s, input int n);
    int h;
    int v;
    h = n % HT;
    v = (n / HT) % VT;
    if (!mid_reset_done && (n / FRAME) == WHITE_F) return 24'hFFFFFF;
    return {8'(h * 7 + salt[s]), 8'(v * 13 + s * 40), 8'(salt[s] ^ (h + v))};
  endfunction

  task automatic model_edge();
    int m;
    if (!power) begin
      k = 0;
      cur_model = 0;
      last_sof_k = -1;
      if (running) mid_reset_done = 1'b1;
      foreach (frame_src[i]) frame_src[i] = 0;
    end else begin
      k++;
      if (k % CLK_DIV == 0) begin
        m = k / CLK_DIV;
        if ((m - 1) % FRAME == 0) begin
          if (int'(src_sel) < NUM_SRC) cur_model = int'(src_sel);
          frame_src[(m - 1) / FRAME] = cur_model;
        end
      end
    end
  endtask

  // Sources present pixel n exactly PIPE_LAT ticks after the counters show it.
  task automatic drive_src();
    int ns;
    ns = k / CLK_DIV - 1 - PIPE_LAT;
    if (ns < 0) ns = 0;
    for (int s = 0; s < NUM_SRC; s++) src_rgb[s*24 +: 24] = src_pix(s, ns);
  endtask

  task automatic check_cycle();
    int ph, m, n, h, v, q, qh, qv;
    logic exp_pe, exp_hs, exp_vs, exp_de;
    logic [23:0] exp_rgb;
    logic [23:0] pins;
    ph = k % CLK_DIV;
    m = k / CLK_DIV;
    n = (m > 0) ? m - 1 : 0;
    h = n % HT;
    v = (n / HT) % VT;
    exp_pe = (ph == CLK_DIV - 1);
    check_val("pix_en", 32'(pix_en), 32'(exp_pe));
    check_val("vga_clk", 32'(VGA_clk), 32'(ph >= CLK_DIV / 2));
    check_val("sof", 32'(sof), 32'(exp_pe && (m % FRAME == 0)));
    check_val("hcount", 32'(hcount), h);
    check_val("vcount", 32'(vcount), v);
    check_val("active", 32'(active), 32'((h < HA) && (v < VA)));
    check_val("frame_cnt", 32'(frame_cnt), (m > 0) ? ((m - 1) / FRAME) % 65536 : 0);

    q = m - 2 - PIPE_LAT;
    exp_hs = ~HPOL;
    exp_vs = ~VPOL;
    exp_de = 1'b0;
    exp_rgb = '0;
    if (q >= 0) begin
      qh = q % HT;
      qv = (q / HT) % VT;
      if (qh >= HA + HF && qh < HA + HF + HS) exp_hs = HPOL;
      if (qv >= VA + VF && qv < VA + VF + VS) exp_vs = VPOL;
      exp_de = (qh < HA) && (qv < VA);
      if (exp_de) exp_rgb = src_pix(frame_src[q / FRAME], q);
    end
    pins = {VGA_Red, VGA_Green, VGA_Blue};
    check_val("VGA_Hsync", 32'(VGA_Hsync), 32'(exp_hs));
    check_val("VGA_Vsync", 32'(VGA_Vsync), 32'(exp_vs));
    check_val("VGA_Display", 32'(VGA_Display), 32'(exp_de));
    check_val("rgb", 32'(pins), 32'(exp_rgb));

    if (!mid_reset_done && ph == 0 && q >= 0 && q / FRAME == WHITE_F) begin
      if (VGA_Display && pins == 24'hFFFFFF) white_on++;
      if (!VGA_Display && pins == 24'h0) white_off++;
    end
    if (!mid_reset_done && ph == 0 && q == (WHITE_F + 1) * FRAME) begin
      check_val("white_pixels", white_on, HA * VA);
      check_val("blank_pixels", white_off, FRAME - HA * VA);
    end

    if (sof) begin
      if (last_sof_k >= 0) check_val("sof_gap", k - last_sof_k, FRAME * CLK_DIV);
      else check_val("first_sof", k, CLK_DIV - 1);
      last_sof_k = k;
      $display("frame start: k=%0d frame_cnt=%0d src_sel=%0d", k, frame_cnt, src_sel);
    end
  endtask

  initial begin
    for (int s = 0; s < NUM_SRC; s++) salt[s] = int'($urandom_range(0, 255));
    foreach (frame_src[i]) frame_src[i] = 0;
    power = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_cycle();
    end
    power = 1'b1;
    running = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_cycle();
      drive_src();
      if (!power) power = 1'b1;
      else if (!mid_reset_done && k % CLK_DIV == 0 && k / CLK_DIV == RST_TICK) power = 1'b0;
      if ($urandom_range(0, 39) == 0) src_sel = SEL_W'($urandom_range(0, 3));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
